// File: rtl/array_20_rw_sched_if.sv
// Request/response bundle between the cache/TLB datapath (master) and the
// RW-port scheduler (slave): read requests, read responses, masked writes, init status.
`timescale 1ns/1ps
interface array_20_rw_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2112,
  parameter int MASK_W = 16
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [MASK_W-1:0] wr_req_mask;
  logic [DATA_W-1:0] wr_req_data;
  logic              init_busy;

  modport master (
    output rd_req_valid, rd_req_addr, rd_resp_ready,
           wr_req_valid, wr_req_addr, wr_req_mask, wr_req_data,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready, init_busy
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_resp_ready,
           wr_req_valid, wr_req_addr, wr_req_mask, wr_req_data,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready, init_busy
  );
endinterface

// File: rtl/array_20_rw_sched.sv
// Single-port RW SRAM scheduler: zero-fills the array after reset, then round-robins
// reads and masked writes onto the one port, buffering read data in a 2-entry FIFO.
`timescale 1ns/1ps
module array_20_rw_sched #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2112,
  parameter int MASK_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  array_20_rw_sched_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {SIDE_RD, SIDE_WR} side_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  side_t             rr_ptr;
  logic              rd_inflight;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wp, fifo_rp;
  logic [1:0]        fifo_cnt;

  logic              pop, push;
  logic [2:0]        credit_use;
  logic              rd_ok, rd_elig, wr_elig, rd_gnt, wr_gnt;

  assign push = rd_inflight;
  assign pop  = (fifo_cnt != 2'd0) && bus.rd_resp_ready;

  // Reads in flight plus buffered entries may never exceed the FIFO depth.
  assign credit_use = {1'b0, fifo_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  assign rd_ok      = credit_use < 3'd2;

  always_comb begin
    state_nxt = state;
    rd_elig   = 1'b0;
    wr_elig   = 1'b0;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = bus.rd_req_addr;
    mem_wmask = bus.wr_req_mask;
    mem_wdata = bus.wr_req_data;
    case (state)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_wmask = '1;
        mem_wdata = '0;
        mem_addr  = init_cnt;
        if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        rd_elig = bus.rd_req_valid && rd_ok;
        wr_elig = bus.wr_req_valid;
        if (rd_elig && (!wr_elig || rr_ptr == SIDE_RD)) rd_gnt = 1'b1;
        else if (wr_elig)                               wr_gnt = 1'b1;
        mem_en    = rd_gnt || wr_gnt;
        mem_wmode = wr_gnt;
        mem_addr  = wr_gnt ? bus.wr_req_addr : bus.rd_req_addr;
      end
      default: state_nxt = ST_INIT;
    endcase
    // The macro must see no access while reset is held, even combinationally.
    if (reset) mem_en = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_cnt    <= '0;
      rr_ptr      <= SIDE_RD;
      rd_inflight <= 1'b0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      if (rd_gnt)      rr_ptr <= SIDE_WR;
      else if (wr_gnt) rr_ptr <= SIDE_RD;
      rd_inflight <= rd_gnt;
      if (push) fifo_wp <= ~fifo_wp;
      if (pop)  fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Macro read data is captured the cycle after the read; storage carries no reset.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[fifo_wp] <= mem_rdata;
  end

  assign bus.rd_resp_valid = (fifo_cnt != 2'd0);
  assign bus.rd_resp_data  = fifo_mem[fifo_rp];
  assign bus.rd_req_ready  = rd_gnt;
  assign bus.wr_req_ready  = wr_gnt;
  assign bus.init_busy     = (state == ST_INIT);
endmodule

// File: tb/tb_array_20_rw_sched.sv
// Bench for array_20_rw_sched: SRAM macro model, behavioural scoreboard checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_array_20_rw_sched;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 2112;
  localparam int MASK_W = 16;
  localparam int DEPTH  = 1024;
  localparam int LANE_W = 132;
  localparam int NWORD  = 66;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  array_20_rw_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en, mem_wmode;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  array_20_rw_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, bit ok, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [DATA_W-1:0] rand_row();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < NWORD; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] ov,
                                               input logic [DATA_W-1:0] nv,
                                               input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] r;
    r = ov;
    for (int i = 0; i < MASK_W; i++)
      if (mask[i]) r[i*LANE_W +: LANE_W] = nv[i*LANE_W +: LANE_W];
    return r;
  endfunction

  function automatic logic [63:0] fold64(input logic [DATA_W-1:0] v);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < DATA_W / 64; i++) f = f ^ v[i*64 +: 64];
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input int r);
    return {NWORD{32'hA5A5_0000 ^ 32'(r)}};
  endfunction

  // SRAM macro: seeded with non-zero junk, 1-cycle read latency, garbage when not reading.
  logic [DATA_W-1:0] macro [DEPTH];
  bit macro_seeded = 1'b0;
  always @(posedge clock) begin
    if (!macro_seeded) begin
      for (int i = 0; i < DEPTH; i++) macro[i] <= {NWORD{32'hDEAD_BEEF ^ 32'(i)}};
      macro_seeded <= 1'b1;
      mem_rdata    <= rand_row();
    end else begin
      if (mem_en && mem_wmode) macro[mem_addr] <= merge(macro[mem_addr], mem_wdata, mem_wmask);
      if (mem_en && !mem_wmode) mem_rdata <= macro[mem_addr];
      else                      mem_rdata <= rand_row();
    end
  end

  // Behavioural reference: array contents, outstanding-read queue, last granted side.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                t;
  } resp_t;

  logic [DATA_W-1:0] gold [DEPTH];
  resp_t             q [$];

  initial begin
    int cyc;
    bit m_init, last_wr, resp_due, pop, rd_ok, rd_el, wr_el, g_rd, g_wr;
    int m_row;
    cyc = 0; m_init = 1'b1; m_row = 0; last_wr = 1'b1;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        chk("rst_mem_en", mem_en == 1'b0, 64'(mem_en), 64'(0));
        chk("rst_resp_valid", bus.rd_resp_valid == 1'b0, 64'(bus.rd_resp_valid), 64'(0));
        chk("rst_readys", {bus.rd_req_ready, bus.wr_req_ready} == 2'b00,
            64'({bus.rd_req_ready, bus.wr_req_ready}), 64'(0));
        chk("rst_init_busy", bus.init_busy == 1'b1, 64'(bus.init_busy), 64'(1));
        q.delete();
        m_init = 1'b1; m_row = 0; last_wr = 1'b1;
        for (int i = 0; i < DEPTH; i++) gold[i] = '0;
      end else if (m_init) begin
        chk("init_busy", bus.init_busy == 1'b1, 64'(bus.init_busy), 64'(1));
        chk("init_mem_en", mem_en == 1'b1, 64'(mem_en), 64'(1));
        chk("init_wmode", mem_wmode == 1'b1, 64'(mem_wmode), 64'(1));
        chk("init_addr", mem_addr == ADDR_W'(m_row), 64'(mem_addr), 64'(m_row));
        chk("init_wmask", mem_wmask == '1, 64'(mem_wmask), 64'(16'hFFFF));
        chk("init_wdata", mem_wdata == '0, fold64(mem_wdata), 64'(0));
        chk("init_readys", {bus.rd_req_ready, bus.wr_req_ready} == 2'b00,
            64'({bus.rd_req_ready, bus.wr_req_ready}), 64'(0));
        chk("init_resp_valid", bus.rd_resp_valid == 1'b0, 64'(bus.rd_resp_valid), 64'(0));
        m_row++;
        if (m_row == DEPTH) m_init = 1'b0;
      end else begin
        resp_due = (q.size() > 0) && (cyc >= q[0].t + 2);
        pop      = resp_due && bus.rd_resp_ready;
        rd_ok    = (q.size() - (pop ? 1 : 0)) < 2;
        rd_el    = bus.rd_req_valid && rd_ok;
        wr_el    = bus.wr_req_valid;
        g_rd     = rd_el && (!wr_el || last_wr);
        g_wr     = wr_el && !g_rd;
        chk("run_init_busy", bus.init_busy == 1'b0, 64'(bus.init_busy), 64'(0));
        chk("rd_req_ready", bus.rd_req_ready == g_rd, 64'(bus.rd_req_ready), 64'(g_rd));
        chk("wr_req_ready", bus.wr_req_ready == g_wr, 64'(bus.wr_req_ready), 64'(g_wr));
        chk("mem_en", mem_en == (g_rd || g_wr), 64'(mem_en), 64'(g_rd || g_wr));
        chk("rd_resp_valid", bus.rd_resp_valid == resp_due, 64'(bus.rd_resp_valid), 64'(resp_due));
        if (resp_due)
          chk("rd_resp_data", bus.rd_resp_data == q[0].data, fold64(bus.rd_resp_data), fold64(q[0].data));
        if (g_rd) begin
          chk("rd_wmode", mem_wmode == 1'b0, 64'(mem_wmode), 64'(0));
          chk("rd_addr", mem_addr == bus.rd_req_addr, 64'(mem_addr), 64'(bus.rd_req_addr));
        end
        if (g_wr) begin
          chk("wr_wmode", mem_wmode == 1'b1, 64'(mem_wmode), 64'(1));
          chk("wr_addr", mem_addr == bus.wr_req_addr, 64'(mem_addr), 64'(bus.wr_req_addr));
          chk("wr_mask", mem_wmask == bus.wr_req_mask, 64'(mem_wmask), 64'(bus.wr_req_mask));
          chk("wr_data", mem_wdata == bus.wr_req_data, fold64(mem_wdata), fold64(bus.wr_req_data));
        end
        if (pop) void'(q.pop_front());
        if (g_rd) begin
          q.push_back('{data: gold[bus.rd_req_addr], t: cyc});
          last_wr = 1'b0;
        end
        if (g_wr) begin
          gold[bus.wr_req_addr] = merge(gold[bus.wr_req_addr], bus.wr_req_data, bus.wr_req_mask);
          last_wr = 1'b1;
        end
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req_valid  = 1'b0;
    bus.rd_req_addr   = '0;
    bus.rd_resp_ready = 1'b0;
    bus.wr_req_valid  = 1'b0;
    bus.wr_req_addr   = '0;
    bus.wr_req_mask   = '0;
    bus.wr_req_data   = '0;
  endtask

  task automatic wait_init(input int start, output int n);
    n = start;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (bus.init_busy) n++;
      else break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, nr, first, last;
    bit [5:0] gseq;
    bit seen;
    logic [DATA_W-1:0] got [3];
    logic [DATA_W-1:0] exp2;

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset in the middle of the zero-fill restarts it from row 0.
    repeat (300) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("mid_init_rst_en", mem_en == 1'b0, 64'(mem_en), 64'(0));
    next();
    reset = 1'b0;
    @(negedge clock);
    chk("restart_row0", mem_addr == '0, 64'(mem_addr), 64'(0));
    chk("restart_resp_valid", bus.rd_resp_valid == 1'b0, 64'(bus.rd_resp_valid), 64'(0));
    wait_init(1, n);
    chk("init_cycles", n == 1024, 64'(n), 64'(1024));
    next();

    // Contested traffic right after init alternates starting with the read side.
    bus.rd_resp_ready = 1'b1;
    bus.rd_req_valid  = 1'b1;
    bus.rd_req_addr   = 10'd1023;
    bus.wr_req_valid  = 1'b1;
    bus.wr_req_addr   = 10'd7;
    bus.wr_req_mask   = '1;
    bus.wr_req_data   = rand_row();
    gseq = '0; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      gseq[i] = bus.rd_req_ready;
      if (bus.rd_resp_valid && !seen) begin
        seen = 1'b1;
        chk("row1023_zero", bus.rd_resp_data == '0, fold64(bus.rd_resp_data), 64'(0));
      end
      next();
      bus.wr_req_data = rand_row();
    end
    chk("grant_alternation", gseq == 6'b010101, 64'(gseq), 64'(6'b010101));
    chk("row1023_returned", seen == 1'b1, 64'(seen), 64'(1));
    idle_inputs();
    bus.rd_resp_ready = 1'b1;
    repeat (3) next();

    // Single-lane write followed immediately by a read of the same row.
    bus.wr_req_valid = 1'b1;
    bus.wr_req_addr  = 10'd5;
    bus.wr_req_mask  = 16'h0001;
    bus.wr_req_data  = '1;
    @(negedge clock);
    chk("t2_wr_ready", bus.wr_req_ready == 1'b1, 64'(bus.wr_req_ready), 64'(1));
    next();
    bus.wr_req_valid = 1'b0;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 10'd5;
    @(negedge clock);
    chk("t2_rd_ready", bus.rd_req_ready == 1'b1, 64'(bus.rd_req_ready), 64'(1));
    next();
    bus.rd_req_valid = 1'b0;
    @(negedge clock);
    chk("t2_no_resp_t1", bus.rd_resp_valid == 1'b0, 64'(bus.rd_resp_valid), 64'(0));
    next();
    @(negedge clock);
    chk("t2_resp_t2", bus.rd_resp_valid == 1'b1, 64'(bus.rd_resp_valid), 64'(1));
    exp2 = {{(DATA_W-LANE_W){1'b0}}, {LANE_W{1'b1}}};
    chk("t2_lane0_data", bus.rd_resp_data == exp2, fold64(bus.rd_resp_data), fold64(exp2));
    next();

    // Backpressure: two reads fit, the third waits for a pop; data returns in order.
    idle_inputs();
    for (int r = 10; r < 13; r++) begin
      bus.wr_req_valid = 1'b1;
      bus.wr_req_addr  = ADDR_W'(r);
      bus.wr_req_mask  = '1;
      bus.wr_req_data  = pat(r);
      next();
    end
    bus.wr_req_valid = 1'b0;
    acc = 0; nr = 0;
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 10'd10;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (bus.rd_req_valid && bus.rd_req_ready) acc++;
      if (bus.rd_resp_valid && bus.rd_resp_ready) begin
        if (nr < 3) got[nr] = bus.rd_resp_data;
        nr++;
      end
      if (i == 4) chk("t4_two_accepted", acc == 2, 64'(acc), 64'(2));
      if (i == 6) chk("t4_third_after_pop", acc == 3, 64'(acc), 64'(3));
      next();
      bus.rd_req_valid  = (acc < 3);
      bus.rd_req_addr   = ADDR_W'(10 + acc);
      bus.rd_resp_ready = (i + 1 == 5) || (i + 1 >= 8);
    end
    chk("t4_resp_count", nr == 3, 64'(nr), 64'(3));
    for (int k = 0; k < 3; k++)
      chk("t4_order", got[k] == pat(10 + k), fold64(got[k]), fold64(pat(10 + k)));

    // Back-to-back reads with the consumer always ready.
    idle_inputs();
    bus.rd_resp_ready = 1'b1;
    acc = 0; nr = 0; first = -1; last = -1;
    for (int j = 0; j < 12; j++) begin
      bus.rd_req_valid = (j < 8);
      bus.rd_req_addr  = ADDR_W'(j + 1);
      @(negedge clock);
      if (bus.rd_req_valid && bus.rd_req_ready) acc++;
      if (bus.rd_resp_valid && bus.rd_resp_ready) begin
        if (first < 0) first = j;
        last = j;
        nr++;
      end
      next();
    end
    chk("t5_accepts", acc == 8, 64'(acc), 64'(8));
    chk("t5_resps", nr == 8, 64'(nr), 64'(8));
    chk("t5_first_resp", first == 2, 64'(first), 64'(2));
    chk("t5_last_resp", last == 9, 64'(last), 64'(9));

    // Randomized traffic on a small row window to provoke read-after-write hazards.
    for (int k = 0; k < 2000; k++) begin
      bus.rd_req_valid  = ($urandom % 4) != 0;
      bus.rd_req_addr   = ADDR_W'($urandom % 16);
      bus.wr_req_valid  = ($urandom % 2) != 0;
      bus.wr_req_addr   = ADDR_W'($urandom % 16);
      bus.wr_req_mask   = MASK_W'($urandom);
      bus.wr_req_data   = rand_row();
      bus.rd_resp_ready = ($urandom % 3) != 0;
      next();
    end

    // Reset while responses are buffered: they are discarded and the fill reruns.
    idle_inputs();
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = 10'd3;
    repeat (4) next();
    reset = 1'b1;
    next();
    next();
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    chk("run_rst_resp_valid", bus.rd_resp_valid == 1'b0, 64'(bus.rd_resp_valid), 64'(0));
    chk("run_rst_row0", mem_addr == '0, 64'(mem_addr), 64'(0));
    wait_init(1, n);
    chk("reinit_cycles", n == 1024, 64'(n), 64'(1024));
    next();
    bus.rd_resp_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = ADDR_W'(r);
      next();
    end
    bus.rd_req_valid = 1'b0;
    repeat (4) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
